// File: rtl/darwin_rx_recv.sv
// Toggle-handshake receiver: captures 16-bit words from RX_REQ/RX_ACK into a FIFO and streams them out as AXIS.
// TLAST is cut at MAX_PKT_WORDS beats or when a lone buffered word has waited IDLE_TIMEOUT cycles.
module darwin_rx_recv #(
  parameter int SYNC_STAGES   = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_PKT_WORDS = 256,
  parameter int IDLE_TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] RX_DATA,
  input  logic        RX_REQ,
  output logic        RX_ACK,
  output logic [15:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic [1:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        OVERRUN
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);
  localparam logic [AW:0]   TWO       = (AW+1)'(2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(MAX_PKT_WORDS - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLED   = SW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {O_EMPTY, O_HOLD, O_VALID} ostate_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_prev;
  logic [SW-1:0]          settle;
  logic                   settled, req_edge;
  logic                   pending, ack_due;
  logic [15:0]            cap_dat, wr_dat;
  logic [15:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, count_nxt, occupancy;
  logic                   hs, space, fifo_wr, take_new, take_cap, go_pend;
  logic                   can_load, load, load_last, last_idx, one_left;
  ostate_t                state;
  logic [IW-1:0]          idx, idx_eff;
  logic [TW-1:0]          idle;

  assign M_AXIS_TKEEP = 2'b11;

  assign settled  = (settle == SETTLED);
  assign req_edge = settled && (sync[SYNC_STAGES-1] ^ req_prev);

  // The output register counts as the FIFO head, so at most FIFO_DEPTH words are ever buffered.
  assign hs        = M_AXIS_TVALID && M_AXIS_TREADY;
  assign occupancy = count + {{AW{1'b0}}, M_AXIS_TVALID};
  assign space     = (occupancy != FULL_LVL) || hs;
  assign take_new  = req_edge && !pending && space;
  assign take_cap  = pending && space;
  assign go_pend   = req_edge && !pending && !space;
  assign fifo_wr   = take_new || take_cap;
  assign wr_dat    = pending ? cap_dat : RX_DATA;

  assign can_load  = !M_AXIS_TVALID || hs;
  assign idx_eff   = !hs ? idx : (M_AXIS_TLAST ? '0 : idx + 1'b1);
  assign last_idx  = (idx_eff == LAST_IDX);
  assign one_left  = (count == ONE);
  assign load      = can_load && ((count >= TWO) ||
                     (one_left && (last_idx || (state == O_HOLD && idle == IDLE_LAST))));
  assign load_last = (count >= TWO) ? last_idx : 1'b1;
  assign count_nxt = count + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      req_prev <= 1'b0;
      settle   <= '0;
      pending  <= 1'b0;
      cap_dat  <= '0;
      ack_due  <= 1'b0;
      RX_ACK   <= 1'b0;
      OVERRUN  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], RX_REQ};
      req_prev <= sync[SYNC_STAGES-1];
      if (!settled) settle <= settle + 1'b1;
      if (go_pend) begin
        pending <= 1'b1;
        cap_dat <= RX_DATA;
      end else if (take_cap) begin
        pending <= 1'b0;
      end
      // A second request while one is still parked means the chip ignored the handshake.
      if (req_edge && pending) OVERRUN <= 1'b1;
      ack_due <= fifo_wr;
      if (ack_due) RX_ACK <= ~RX_ACK;
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= O_EMPTY;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      idx           <= '0;
      idle          <= '0;
    end else begin
      if (hs) idx <= idx_eff;
      if (fifo_wr || load || state != O_HOLD) idle <= '0;
      else                                     idle <= idle + 1'b1;
      if (can_load) begin
        if (load) begin
          state         <= O_VALID;
          M_AXIS_TVALID <= 1'b1;
          M_AXIS_TDATA  <= mem[rd_ptr];
          M_AXIS_TLAST  <= load_last;
        end else begin
          state         <= (count_nxt == ONE) ? O_HOLD : O_EMPTY;
          M_AXIS_TVALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_darwin_rx_recv.sv
// Directed bench for darwin_rx_recv: dut_a uses default parameters, dut_b cuts packets at 4 words.
module tb_darwin_rx_recv;

  localparam int IDLE_T = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_a, ack_a, tvalid_a, tlast_a, tready_a, ovr_a;
  logic [15:0] data_a, tdata_a;
  logic [1:0]  tkeep_a;
  logic        req_b, ack_b, tvalid_b, tlast_b, tready_b, ovr_b;
  logic [15:0] data_b, tdata_b;
  logic [1:0]  tkeep_b;

  darwin_rx_recv dut_a (
    .clk(clk), .rst_n(rst_n), .RX_DATA(data_a), .RX_REQ(req_a), .RX_ACK(ack_a),
    .M_AXIS_TDATA(tdata_a), .M_AXIS_TVALID(tvalid_a), .M_AXIS_TKEEP(tkeep_a),
    .M_AXIS_TLAST(tlast_a), .M_AXIS_TREADY(tready_a), .OVERRUN(ovr_a)
  );

  darwin_rx_recv #(.MAX_PKT_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX_DATA(data_b), .RX_REQ(req_b), .RX_ACK(ack_b),
    .M_AXIS_TDATA(tdata_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TKEEP(tkeep_b),
    .M_AXIS_TLAST(tlast_b), .M_AXIS_TREADY(tready_b), .OVERRUN(ovr_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [16:0] beats_a[$];
  logic [16:0] beats_b[$];
  int   ack_cnt_a = 0;
  int   ack_cnt_b = 0;
  logic ack_a_q = 1'b0;
  logic ack_b_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beats are recorded at the falling edge, i.e. just before the rising edge that completes them.
  always @(negedge clk) begin
    if (tvalid_a && tready_a) beats_a.push_back({tlast_a, tdata_a});
    if (tvalid_b && tready_b) beats_b.push_back({tlast_b, tdata_b});
    if (ack_a !== ack_a_q) ack_cnt_a = ack_cnt_a + 1;
    if (ack_b !== ack_b_q) ack_cnt_b = ack_cnt_b + 1;
    ack_a_q = ack_a;
    ack_b_q = ack_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Chip side: present data, toggle request, report cycles until the ack toggles (0 = none within budget).
  task automatic send(input bit which, input logic [15:0] d, input int budget, output int lat);
    logic a0;
    a0 = which ? ack_b : ack_a;
    if (which) begin data_b = d; req_b = ~req_b; end
    else       begin data_a = d; req_a = ~req_a; end
    lat = 0;
    for (int k = 1; k <= budget && lat == 0; k++) begin
      @(posedge clk); #1;
      if ((which ? ack_b : ack_a) !== a0) lat = k;
    end
  endtask

  task automatic wait_beats(input bit which, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if ((which ? beats_b.size() : beats_a.size()) >= n) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int   lat, base, snap, t0, k;
    bit   ok, all_ok;
    logic a0;
    logic [16:0] bt;

    rst_n = 1'b0;
    req_a = 1'b0; data_a = '0; tready_a = 1'b0;
    req_b = 1'b0; data_b = '0; tready_b = 1'b0;
    #7;
    check("rst_ack",    {31'd0, ack_a},    32'd0);
    check("rst_tvalid", {31'd0, tvalid_a}, 32'd0);
    check("rst_tlast",  {31'd0, tlast_a},  32'd0);
    check("rst_tdata",  {16'd0, tdata_a},  32'd0);
    check("rst_overrun",{31'd0, ovr_a},    32'd0);
    check("rst_tkeep",  {30'd0, tkeep_a},  32'd3);
    #20;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Single word: ack after SYNC_STAGES+2 cycles, lone beat with TLAST after the idle timeout.
    tready_a = 1'b1;
    base = beats_a.size();
    send(1'b0, 16'hA5A5, 20, lat);
    check("single_ack_latency", lat, 32'd4);
    t0 = cyc;
    ok = 1'b0;
    for (int j = 0; j < IDLE_T + 200 && !ok; j++) begin
      if (tvalid_a) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("single_beat_seen", {31'd0, ok}, 32'd1);
    check("single_timeout_window",
          {31'd0, ((cyc - t0) >= IDLE_T - 2) && ((cyc - t0) <= IDLE_T + 2)}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("single_beat_count", beats_a.size() - base, 32'd1);
    bt = (beats_a.size() > base) ? beats_a[base] : 17'h0;
    check("single_beat_data", {16'd0, bt[15:0]}, 32'hA5A5);
    check("single_beat_last", {31'd0, bt[16]},   32'd1);

    // Burst of 5 words at the chip's maximum rate.
    base = beats_a.size();
    snap = ack_cnt_a;
    all_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 16'(i), 20, lat);
      if (lat == 0) all_ok = 1'b0;
    end
    check("burst_all_acked", {31'd0, all_ok}, 32'd1);
    wait_beats(1'b0, base + 5, IDLE_T + 300, ok);
    check("burst_beats_seen", {31'd0, ok}, 32'd1);
    check("burst_ack_toggles", ack_cnt_a - snap, 32'd5);
    for (int i = 0; i < 5; i++) begin
      bt = (beats_a.size() > base + i) ? beats_a[base + i] : 17'h0;
      check($sformatf("burst_data_%0d", i), {16'd0, bt[15:0]}, 32'(i + 1));
      check($sformatf("burst_last_%0d", i), {31'd0, bt[16]},   {31'd0, i == 4});
    end

    // Length cut on the 4-word instance: TLAST on beats 4 and 8, beat 9 via timeout.
    tready_b = 1'b1;
    for (int i = 0; i < 9; i++) send(1'b1, 16'h0010 + 16'(i), 20, lat);
    wait_beats(1'b1, 9, IDLE_T + 300, ok);
    check("cut_beats_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      bt = (beats_b.size() > i) ? beats_b[i] : 17'h0;
      check($sformatf("cut_data_%0d", i), {16'd0, bt[15:0]}, 32'h10 + 32'(i));
      check($sformatf("cut_last_%0d", i), {31'd0, bt[16]},   {31'd0, i == 3 || i == 7 || i == 8});
    end

    // Backpressure: 16 words accepted, the 17th parks without an ack.
    tready_a = 1'b0;
    base = beats_a.size();
    snap = ack_cnt_a;
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 16'h0100 + 16'(i), 20, lat);
      if (lat == 0) all_ok = 1'b0;
    end
    check("bp_16_acked", {31'd0, all_ok}, 32'd1);
    send(1'b0, 16'h0110, 20, lat);
    check("bp_17th_withheld", lat, 32'd0);
    check("bp_ack_count", ack_cnt_a - snap, 32'd16);
    check("bp_tvalid", {31'd0, tvalid_a}, 32'd1);
    check("bp_tdata_first", {16'd0, tdata_a}, 32'h0100);
    repeat (10) @(posedge clk);
    #1;
    check("bp_tdata_stable", {16'd0, tdata_a}, 32'h0100);
    check("bp_tlast_stable", {31'd0, tlast_a}, 32'd0);

    // Handshake violation while the 17th word is parked.
    send(1'b0, 16'hDEAD, 10, lat);
    check("ovr_no_ack", lat, 32'd0);
    check("ovr_flag_set", {31'd0, ovr_a}, 32'd1);

    a0 = ack_a;
    tready_a = 1'b1;
    k = 0;
    for (int j = 1; j <= 6 && k == 0; j++) begin
      @(posedge clk); #1;
      if (ack_a !== a0) k = j;
    end
    check("bp_17th_ack_after_pop", {31'd0, (k >= 1) && (k <= 2)}, 32'd1);
    wait_beats(1'b0, base + 17, IDLE_T + 300, ok);
    check("bp_beats_seen", {31'd0, ok}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_beat_count", beats_a.size() - base, 32'd17);
    for (int i = 0; i < 17; i++) begin
      bt = (beats_a.size() > base + i) ? beats_a[base + i] : 17'h0;
      check($sformatf("bp_data_%0d", i), {16'd0, bt[15:0]}, 32'h100 + 32'(i));
      check($sformatf("bp_last_%0d", i), {31'd0, bt[16]},   {31'd0, i == 16});
    end
    check("ovr_sticky", {31'd0, ovr_a}, 32'd1);

    // RX_REQ held high through reset release must not create a word.
    rst_n = 1'b0;
    req_a = 1'b1;
    data_a = 16'hBEEF;
    #1;
    check("rst2_overrun_clear", {31'd0, ovr_a}, 32'd0);
    #30;
    snap = ack_cnt_a;
    base = beats_a.size();
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst2_no_ack_toggle", ack_cnt_a - snap, 32'd0);
    check("rst2_ack_low", {31'd0, ack_a}, 32'd0);
    repeat (IDLE_T + 20) @(posedge clk);
    #1;
    check("rst2_no_word", {31'd0, tvalid_a}, 32'd0);
    check("rst2_no_beat", beats_a.size() - base, 32'd0);
    send(1'b0, 16'h1234, 20, lat);
    check("rst2_next_word_ack", lat, 32'd4);

    // Reset in the middle of a backpressured burst.
    tready_a = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 16'h0200 + 16'(i), 20, lat);
    check("mid_tvalid_before", {31'd0, tvalid_a}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_tvalid_drop", {31'd0, tvalid_a}, 32'd0);
    check("mid_tdata_zero",  {16'd0, tdata_a},  32'd0);
    check("mid_tlast_zero",  {31'd0, tlast_a},  32'd0);
    check("mid_ack_zero",    {31'd0, ack_a},    32'd0);
    check("mid_overrun_zero",{31'd0, ovr_a},    32'd0);
    #30;
    snap = ack_cnt_a;
    @(negedge clk); rst_n = 1'b1;
    tready_a = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_discarded", {31'd0, tvalid_a}, 32'd0);
    check("mid_no_ack", ack_cnt_a - snap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
